muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 34 +++
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM state codes
// and reset polarity.
package muldiv_unit_pkg;

  localparam logic RST_ENABLE = 1'b1;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_MADD  = 3'b010,
    OP_MADDU = 3'b011,
    OP_MSUB  = 3'b100,
    OP_MSUBU = 3'b101,
    OP_DIV   = 3'b110,
    OP_DIVU  = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  function automatic logic is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_acc(input op_e op);
    return (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle of the multiply/divide unit.
interface muldiv_unit_if #(parameter int WIDTH = 32);

  logic                 start_i;
  logic [2:0]           op_i;
  logic [WIDTH-1:0]     op1_i;
  logic [WIDTH-1:0]     op2_i;
  logic [2*WIDTH-1:0]   hilo_i;
  logic                 annul_i;
  logic [2*WIDTH-1:0]   result_o;
  logic                 ready_o;
  logic                 busy_o;
  logic                 div_zero_o;

  modport master (
    output start_i, op_i, op1_i, op2_i, hilo_i, annul_i,
    input  result_o, ready_o, busy_o, div_zero_o
  );

  modport slave (
    input  start_i, op_i, op1_i, op2_i, hilo_i, annul_i,
    output result_o, ready_o, busy_o, div_zero_o
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply / multiply-accumulate / divide unit: radix-2 shift-add
// multiply and restoring divide sharing one WIDTH+1-bit adder.
import muldiv_unit_pkg::*;

// state  | meaning
// IDLE   | waiting for start_i
// MUL    | one shift-add step per cycle, WIDTH cycles
// DIV    | one restoring step per cycle, WIDTH cycles
// ACC    | add/subtract product to/from latched hilo
// DONE   | ready_o pulse, result_o valid
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst,
  muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e               state_q;
  op_e                  op_q;
  logic [CW-1:0]        cnt_q;
  logic                 sign1_q, sign2_q;
  logic [WIDTH-1:0]     hi_q, lo_q, opb_q;
  logic [2*WIDTH-1:0]   hilo_q, result_q;
  logic                 ready_q, dz_q;

  logic                 sgn_in, div_in;
  logic [WIDTH-1:0]     mag1, mag2;
  logic [WIDTH:0]       add_a, add_b, add_sum;
  logic                 add_cin;
  logic [WIDTH-1:0]     step_hi, step_lo;
  logic [2*WIDTH-1:0]   prod_fix, div_fix, acc_res;
  logic                 last_step, signed_q;

  assign sgn_in = ~bus.op_i[0];
  assign div_in = is_div(op_e'(bus.op_i));
  assign mag1   = (sgn_in && bus.op1_i[WIDTH-1]) ? -bus.op1_i : bus.op1_i;
  assign mag2   = (sgn_in && bus.op2_i[WIDTH-1]) ? -bus.op2_i : bus.op2_i;

  // MUL: hi + (lo[0] ? multiplicand : 0). DIV: {rem, next dividend bit} - divisor.
  always_comb begin
    add_a   = {1'b0, hi_q};
    add_b   = '0;
    add_cin = 1'b0;
    if (state_q == S_DIV) begin
      add_a   = {hi_q, lo_q[WIDTH-1]};
      add_b   = ~{1'b0, opb_q};
      add_cin = 1'b1;
    end else if (lo_q[0]) begin
      add_b = {1'b0, opb_q};
    end
  end

  assign add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};

  always_comb begin
    if (state_q == S_DIV) begin
      step_hi = add_sum[WIDTH] ? add_a[WIDTH-1:0] : add_sum[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], ~add_sum[WIDTH]};
    end else begin
      step_hi = add_sum[WIDTH:1];
      step_lo = {add_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  assign signed_q  = ~op_q[0];
  assign last_step = (cnt_q == CW'(WIDTH - 1));
  assign prod_fix  = (sign1_q ^ sign2_q) ? -{step_hi, step_lo} : {step_hi, step_lo};
  assign div_fix   = {(signed_q && sign1_q) ? -step_hi : step_hi,
                      (sign1_q ^ sign2_q)   ? -step_lo : step_lo};
  assign acc_res   = (op_q == OP_MADD || op_q == OP_MADDU) ? hilo_q + {hi_q, lo_q}
                                                            : hilo_q - {hi_q, lo_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      cnt_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      hilo_q   <= '0;
      result_q <= '0;
      ready_q  <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      dz_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            op_q    <= op_e'(bus.op_i);
            sign1_q <= sgn_in & bus.op1_i[WIDTH-1];
            sign2_q <= sgn_in & bus.op2_i[WIDTH-1];
            hilo_q  <= bus.hilo_i;
            cnt_q   <= '0;
            hi_q    <= '0;
            if (div_in) begin
              lo_q  <= mag1;
              opb_q <= mag2;
              if (bus.op2_i == '0) begin
                state_q  <= S_DONE;
                result_q <= '0;
                ready_q  <= 1'b1;
                dz_q     <= 1'b1;
              end else begin
                state_q <= S_DIV;
              end
            end else begin
              lo_q    <= mag2;
              opb_q   <= mag1;
              state_q <= S_MUL;
            end
          end
        end
        S_MUL, S_DIV: begin
          if (bus.annul_i) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            if (!last_step) begin
              hi_q <= step_hi;
              lo_q <= step_lo;
            end else if (state_q == S_DIV) begin
              result_q <= div_fix;
              ready_q  <= 1'b1;
              state_q  <= S_DONE;
            end else if (is_acc(op_q)) begin
              {hi_q, lo_q} <= prod_fix;
              state_q      <= S_ACC;
            end else begin
              result_q <= prod_fix;
              ready_q  <= 1'b1;
              state_q  <= S_DONE;
            end
          end
        end
        S_ACC: begin
          if (bus.annul_i) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= acc_res;
            ready_q  <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.result_o   = result_q;
  assign bus.ready_o    = ready_q;
  assign bus.busy_o     = (state_q != S_IDLE);
  assign bus.div_zero_o = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops
// against an arithmetic reference, and annul/reset sequences.
module tb_muldiv_unit;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] last_exp = '0;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] h;
    logic [63:0] exp_res;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] h);
    longint sa, sb, q, r;
    logic [63:0] p;
    if (op[0]) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    if (op[2:1] == 2'b11) begin
      if (b == 32'd0) return {1'b1, 64'd0};
      q = sa / sb;
      r = sa % sb;
      return {1'b0, r[31:0], q[31:0]};
    end
    p = sa * sb;
    case (op[2:1])
      2'b01:   return {1'b0, h + p};
      2'b10:   return {1'b0, h - p};
      default: return {1'b0, p};
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] b);
    if (op[2:1] == 2'b11) return (b == 32'd0) ? 1 : W + 1;
    if (op[2:1] == 2'b01 || op[2:1] == 2'b10) return W + 2;
    return W + 1;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Caller is just after a clk edge with the DUT idle; returns just after the
  // edge that follows the ready cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] h, output logic [63:0] res, output logic dz,
                        output int lat, output logic qual_ok);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.op1_i   = a;
    bus.op2_i   = b;
    bus.hilo_i  = h;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.op_i    = 3'($urandom);
    bus.op1_i   = $urandom;
    bus.op2_i   = $urandom;
    bus.hilo_i  = {$urandom, $urandom};
    lat = -1; res = '0; dz = 1'b0; qual_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!bus.busy_o) qual_ok = 1'b0;
      if (bus.ready_o) begin
        lat = c; res = bus.result_o; dz = bus.div_zero_o;
        break;
      end
      if (bus.div_zero_o) qual_ok = 1'b0;
    end
    @(posedge clk); #1;
    if (bus.busy_o || bus.ready_o || bus.div_zero_o) qual_ok = 1'b0;
  endtask

  task automatic do_vec(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] h, input logic [63:0] er,
                        input logic edz, input int elat);
    logic [63:0] res;
    logic        dz, q;
    int          lat;
    run_op(op, a, b, h, res, dz, lat, q);
    check({tag, "_result"}, res, er);
    check({tag, "_divzero"}, 64'(dz), 64'(edz));
    check({tag, "_latency"}, 64'(lat), 64'(elat));
    check({tag, "_busy_qual"}, 64'(q), 64'd1);
    last_exp = er;
  endtask

  vec_t vecs[$];
  logic [64:0] m;
  logic [2:0]  rop;
  logic [31:0] ra, rb;
  logic [63:0] rh;
  logic        saw_ready;

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.op_i = '0; bus.op1_i = '0; bus.op2_i = '0;
    bus.hilo_i = '0; bus.annul_i = 1'b0;
    #2;
    check("reset_state", {bus.result_o[61:0], bus.ready_o, bus.busy_o} | 64'(bus.div_zero_o), 64'd0);

    vecs.push_back('{3'b000, 32'hFFFF_FFFE, 32'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 33});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 33});
    vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0, 64'h0000_0000_8000_0000, 1'b0, 33});
    vecs.push_back('{3'b101, 32'd3, 32'd5, 64'h10, 64'h1, 1'b0, 34});
    vecs.push_back('{3'b111, 32'h1234_5678, 32'd0, 64'd0, 64'd0, 1'b1, 1});
    vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 64'hFFFF_FFFE_0000_0001, 1'b0, 33});
    vecs.push_back('{3'b010, 32'hFFFF_FFFE, 32'd3, 64'h64, 64'h5E, 1'b0, 34});
    vecs.push_back('{3'b111, 32'hFFFF_FFFF, 32'd16, 64'd0, 64'h0000_000F_0FFF_FFFF, 1'b0, 33});
    vecs.push_back('{3'b110, 32'd7, 32'hFFFF_FFFE, 64'd0, 64'h0000_0001_FFFF_FFFD, 1'b0, 33});
    vecs.push_back('{3'b100, 32'd2, 32'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0, 34});
    vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd0, 64'd0, 64'd0, 1'b1, 1});
    vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_FFFF_FFFD, 1'b0, 34});

    #20;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++)
      do_vec($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].h,
             vecs[i].exp_res, vecs[i].exp_dz, vecs[i].exp_lat);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom);
      ra  = pick();
      rb  = pick();
      rh  = {pick(), pick()};
      m   = ref_model(rop, ra, rb, rh);
      do_vec($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, rh, m[63:0], m[64], ref_lat(rop, rb));
    end

    // start with annul in IDLE is not accepted
    bus.start_i = 1'b1; bus.annul_i = 1'b1; bus.op_i = 3'b000;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.annul_i = 1'b0;
    check("annul_idle_busy", 64'(bus.busy_o), 64'd0);

    // DIV annulled in cycle 10, MULTU started in cycle 11
    bus.start_i = 1'b1; bus.op_i = 3'b110; bus.op1_i = 32'd100; bus.op2_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    saw_ready = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (bus.ready_o) saw_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.annul_i = 1'b1;
    @(negedge clk);
    if (bus.ready_o) saw_ready = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    check("annul_div_busy", 64'(bus.busy_o), 64'd0);
    check("annul_div_noready", 64'(saw_ready | bus.ready_o), 64'd0);
    check("annul_div_result_hold", bus.result_o, last_exp);
    do_vec("after_annul_multu", 3'b001, 32'd7, 32'd6, 64'd0, 64'h2A, 1'b0, 33);

    // MADD annulled while in ACC
    bus.start_i = 1'b1; bus.op_i = 3'b010; bus.op1_i = 32'd9; bus.op2_i = 32'd9; bus.hilo_i = 64'd1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    saw_ready = 1'b0;
    for (int c = 1; c <= W; c++) begin
      @(negedge clk);
      if (bus.ready_o) saw_ready = 1'b1;
      @(posedge clk); #1;
    end
    bus.annul_i = 1'b1;
    @(negedge clk);
    if (bus.ready_o) saw_ready = 1'b1;
    @(posedge clk); #1;
    bus.annul_i = 1'b0;
    @(negedge clk);
    check("annul_acc_busy", 64'(bus.busy_o), 64'd0);
    check("annul_acc_noready", 64'(saw_ready | bus.ready_o), 64'd0);
    check("annul_acc_result_hold", bus.result_o, last_exp);
    @(posedge clk); #1;

    // asynchronous reset in cycle 5 of a MULT
    bus.start_i = 1'b1; bus.op_i = 3'b000; bus.op1_i = 32'd5; bus.op2_i = 32'd5;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_result", bus.result_o, 64'd0);
    check("async_rst_flags", {61'd0, bus.ready_o, bus.busy_o, bus.div_zero_o}, 64'd0);
    #2;
    rst = 1'b0;
    do_vec("first_after_rst", 3'b000, 32'hFFFF_FFFD, 32'd4, 64'd0, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
